// File: rtl/hex_display_arbiter_if.sv
// Bus between the display arbiter and its requesters.
// Carries the request levels and data, plus the grant pulse and the display drive.
interface hex_display_arbiter_if #(
    parameter int NUM_REQ = 4,
    parameter int DATA_W  = 8
);
    logic [NUM_REQ-1:0]        req;
    logic [NUM_REQ*DATA_W-1:0] req_data;
    logic [NUM_REQ-1:0]        grant;
    logic [3:0]                disp_hi;
    logic [3:0]                disp_lo;
    logic [2:0]                disp_src;
    logic                      disp_valid;
    logic                      busy;

    modport master (
        output req, req_data,
        input  grant, disp_hi, disp_lo, disp_src, disp_valid, busy
    );

    modport slave (
        input  req, req_data,
        output grant, disp_hi, disp_lo, disp_src, disp_valid, busy
    );
endinterface

// File: rtl/hex_display_arbiter.sv
// Round-robin arbiter sharing one two-digit hex display among NUM_REQ requesters.
// The granted byte is latched and held on the display for HOLD_CYCLES after the grant cycle.
module hex_display_arbiter #(
    parameter int NUM_REQ     = 4,
    parameter int DATA_W      = 8,
    parameter int HOLD_CYCLES = 50000000
) (
    input logic                  clock,
    input logic                  reset,
    hex_display_arbiter_if.slave bus
);
    localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int CNT_W = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;

    typedef enum logic [1:0] {IDLE, GRANT, HOLD} state_t;

    state_t            state;
    logic [PTR_W-1:0]  last;
    logic [PTR_W-1:0]  winner;
    logic [CNT_W-1:0]  cnt;
    logic [DATA_W-1:0] win_data;

    // First set request bit strictly after 'from', wrapping modulo NUM_REQ.
    function automatic logic [PTR_W-1:0] pick(input logic [NUM_REQ-1:0] r,
                                              input logic [PTR_W-1:0]   from);
        logic [PTR_W-1:0] w;
        logic             found;
        int               idx;
        w     = '0;
        found = 1'b0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            idx = (int'(from) + k) % NUM_REQ;
            if (!found && r[idx]) begin
                found = 1'b1;
                w     = PTR_W'(idx);
            end
        end
        return w;
    endfunction

    assign winner   = pick(bus.req, last);
    assign win_data = bus.req_data[int'(winner)*DATA_W +: DATA_W];

    always_ff @(posedge clock) begin
        if (reset) begin
            state          <= IDLE;
            last           <= PTR_W'(NUM_REQ - 1);
            cnt            <= '0;
            bus.grant      <= '0;
            bus.disp_hi    <= 4'h0;
            bus.disp_lo    <= 4'h0;
            bus.disp_src   <= 3'd0;
            bus.disp_valid <= 1'b0;
            bus.busy       <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    bus.grant <= '0;
                    if (bus.req != '0) begin
                        bus.disp_hi    <= win_data[7:4];
                        bus.disp_lo    <= win_data[3:0];
                        bus.disp_src   <= 3'(winner);
                        bus.disp_valid <= 1'b1;
                        bus.grant      <= {{(NUM_REQ-1){1'b0}}, 1'b1} << winner;
                        bus.busy       <= 1'b1;
                        last           <= winner;
                        state          <= GRANT;
                    end
                end
                GRANT: begin
                    bus.grant <= '0;
                    cnt       <= CNT_W'(HOLD_CYCLES - 1);
                    state     <= HOLD;
                end
                HOLD: begin
                    // Exit on the edge where the counter is already zero, so it never wraps.
                    if (cnt == '0) begin
                        bus.busy <= 1'b0;
                        state    <= IDLE;
                    end else begin
                        cnt <= cnt - CNT_W'(1);
                    end
                end
                default: begin
                    bus.grant <= '0;
                    bus.busy  <= 1'b0;
                    state     <= IDLE;
                end
            endcase
        end
    end
endmodule
